// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : csa_accumulator
// Description : Streaming multi-operand accumulator. Beats are compressed into
//               a redundant sum/carry pair; the last beat of a group triggers
//               a chunked carry-propagate resolve and a handshaked result.
//               Optional macro CSA_ACC_OVERFLOW_EN adds the out_overflow port.
// Revision    : 1.0 - initial release
// ============================================================================
module csa_accumulator #(
    parameter int BIT_LEN   = 19,
    parameter int ACC_EXT   = 6,
    parameter int CHUNK_LEN = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BIT_LEN-1:0]         in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BIT_LEN+ACC_EXT-1:0] out_data
`ifdef CSA_ACC_OVERFLOW_EN
    ,
    output logic                       out_overflow
`endif
);

    localparam int ACC_LEN = BIT_LEN + ACC_EXT;
    localparam int NCHUNK  = ACC_LEN / CHUNK_LEN;
    localparam int KW      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] C_LAST_K = KW'(NCHUNK - 1);

    generate
        if ((BIT_LEN + ACC_EXT) % CHUNK_LEN != 0) begin : g_chunk_check
            $error("csa_accumulator: ACC_LEN must be a multiple of CHUNK_LEN");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    state_t               r_state;
    logic [ACC_LEN-1:0]   r_s;
    logic [ACC_LEN-1:0]   r_c;
    logic [KW-1:0]        r_k;
    logic                 r_cr;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [ACC_LEN-1:0]   r_out_data;

    logic [ACC_LEN-1:0]   w_x;
    logic [ACC_LEN-2:0]   w_maj_lo;
    logic [CHUNK_LEN:0]   w_chunk_sum;
    logic [ACC_LEN-1:0]   w_s_res;
    logic                 w_accept;
    logic                 w_last_chunk;

    assign w_x          = {{ACC_EXT{1'b0}}, in_data};
    assign w_accept     = in_valid & r_in_ready;
    assign w_last_chunk = (r_k == C_LAST_K);

    // Only the majority bits that survive the left shift are kept here.
    assign w_maj_lo = (r_s[ACC_LEN-2:0] & r_c[ACC_LEN-2:0])
                    | (r_s[ACC_LEN-2:0] & w_x[ACC_LEN-2:0])
                    | (r_c[ACC_LEN-2:0] & w_x[ACC_LEN-2:0]);

    always_comb begin
        w_chunk_sum = {1'b0, r_s[r_k*CHUNK_LEN +: CHUNK_LEN]}
                    + {1'b0, r_c[r_k*CHUNK_LEN +: CHUNK_LEN]}
                    + {{CHUNK_LEN{1'b0}}, r_cr};
        w_s_res = r_s;
        w_s_res[r_k*CHUNK_LEN +: CHUNK_LEN] = w_chunk_sum[CHUNK_LEN-1:0];
    end

`ifdef CSA_ACC_OVERFLOW_EN
    logic r_ovf;
    logic r_out_overflow;
    logic w_maj_top;

    assign w_maj_top = (r_s[ACC_LEN-1] & r_c[ACC_LEN-1])
                     | (r_s[ACC_LEN-1] & w_x[ACC_LEN-1])
                     | (r_c[ACC_LEN-1] & w_x[ACC_LEN-1]);
    assign out_overflow = r_out_overflow;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_s         <= '0;
            r_c         <= '0;
            r_k         <= '0;
            r_cr        <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
`ifdef CSA_ACC_OVERFLOW_EN
            r_ovf          <= 1'b0;
            r_out_overflow <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_s <= r_s ^ r_c ^ w_x;
                        r_c <= {w_maj_lo, 1'b0};
`ifdef CSA_ACC_OVERFLOW_EN
                        r_ovf <= r_ovf | w_maj_top;
`endif
                        if (in_last) begin
                            r_state    <= S_RESOLVE;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_state    <= S_ACCUM;
                        end
                    end else if (r_state == S_IDLE) begin
                        r_s <= '0;
                        r_c <= '0;
                    end
                end

                S_RESOLVE: begin
                    r_s  <= w_s_res;
                    r_cr <= w_chunk_sum[CHUNK_LEN];
                    r_k  <= r_k + 1'b1;
                    if (w_last_chunk) begin
                        // Final chunk: the carry-out leaves the accumulator width.
                        r_c         <= '0;
                        r_cr        <= 1'b0;
                        r_k         <= '0;
                        r_state     <= S_OUTPUT;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_s_res;
`ifdef CSA_ACC_OVERFLOW_EN
                        r_ovf          <= r_ovf | w_chunk_sum[CHUNK_LEN];
                        r_out_overflow <= r_ovf | w_chunk_sum[CHUNK_LEN];
`endif
                    end
                end

                S_OUTPUT: begin
                    if (out_ready) begin
                        r_s         <= '0;
                        r_c         <= '0;
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_data  <= '0;
                        r_in_ready  <= 1'b1;
`ifdef CSA_ACC_OVERFLOW_EN
                        r_ovf          <= 1'b0;
                        r_out_overflow <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_csa_accumulator
// Description : Self-checking bench for csa_accumulator; directed groups plus
//               random groups compared against an integer-sum reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csa_accumulator;

    localparam int BIT_LEN   = 8;
    localparam int ACC_EXT   = 4;
    localparam int CHUNK_LEN = 4;
    localparam int ACC_LEN   = BIT_LEN + ACC_EXT;
    localparam int NCHUNK    = ACC_LEN / CHUNK_LEN;
    localparam int MODULUS   = 1 << ACC_LEN;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] in_data;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_LEN-1:0] out_data;
`ifdef CSA_ACC_OVERFLOW_EN
    logic               out_overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csa_accumulator #(
        .BIT_LEN   (BIT_LEN),
        .ACC_EXT   (ACC_EXT),
        .CHUNK_LEN (CHUNK_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef CSA_ACC_OVERFLOW_EN
        ,
        .out_overflow (out_overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat after some idle cycles and hold it until accepted.
    task automatic send_beat(input logic [BIT_LEN-1:0] d, input logic last, input int bubbles);
        int t;
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (bubbles) tick();
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        t = 0;
        while (!in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the last beat was accepted; checks latency, result,
    // stability while back-pressured and the return to IDLE.
    task automatic receive(input int exp_sum, input int hold, input bit press_input);
        int lat;
        logic [ACC_LEN-1:0] exp_data;
        bit exp_ovf;
        exp_data  = ACC_LEN'(exp_sum % MODULUS);
        exp_ovf   = (exp_sum >= MODULUS);
        out_ready = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            tick();
            lat++;
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("latency", 32'(lat), 32'(NCHUNK));
        check("out_data", 32'(out_data), 32'(exp_data));
`ifdef CSA_ACC_OVERFLOW_EN
        check("out_overflow", 32'(out_overflow), 32'(exp_ovf));
`else
        if (exp_ovf) n_checks = n_checks + 0;
`endif
        if (press_input) begin
            in_valid = 1'b1;
            in_data  = 8'h11;
            in_last  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(exp_data));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_valid", 32'(out_valid), 32'd0);
        check("post_data", 32'(out_data), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int sum;
        int len;
        int saw_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_release_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back three-beat group.
        send_beat(8'h05, 1'b0, 0);
        send_beat(8'h03, 1'b0, 0);
        send_beat(8'h07, 1'b1, 0);
        receive(32'h00F, 0, 1'b0);

        // Single-beat group.
        send_beat(8'hFF, 1'b1, 0);
        receive(32'h0FF, 0, 1'b0);

        // 17 x 0xFF with bubbles: wraps past 2^12.
        for (int i = 0; i < 17; i++) send_beat(8'hFF, (i == 16), i % 3);
        receive(17 * 255, 0, 1'b0);

        // Back-pressure for 10 cycles with a new beat waiting.
        send_beat(8'h21, 1'b0, 0);
        send_beat(8'h22, 1'b1, 1);
        receive(32'h043, 10, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        receive(32'h011, 0, 1'b0);

        // Reset while resolving chunk 1.
        send_beat(8'h10, 1'b0, 0);
        send_beat(8'h20, 1'b1, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        saw_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) saw_valid = 1;
        end
        check("midrst_no_output", 32'(saw_valid), 32'd0);
        check("midrst_idle_ready", 32'(in_ready), 32'd1);
        send_beat(8'h01, 1'b0, 0);
        send_beat(8'h01, 1'b1, 0);
        receive(2, 0, 1'b0);

        // 16 x 0xFF: full ripple across all chunks, no overflow.
        for (int i = 0; i < 16; i++) send_beat(8'hFF, (i == 15), 0);
        receive(16 * 255, 0, 1'b0);

        // Random groups against the integer-sum reference.
        for (int g = 0; g < 25; g++) begin
            sum = 0;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                logic [BIT_LEN-1:0] d;
                d = BIT_LEN'($urandom_range(0, 255));
                sum += int'(d);
                send_beat(d, (i == len - 1), $urandom_range(0, 2));
            end
            receive(sum, $urandom_range(0, 3), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
Streaming multi-operand accumulator. Input words are compressed into a redundant sum/carry register pair, one 3:2 full-adder compression per accepted beat, so the accumulate path has no carry chain. On the last beat of a group, a chunked carry-propagate stage resolves the redundant pair, CHUNK_LEN bits per cycle, and presents the binary total on an output handshake. The block sits after the bitwise CSA arrays in the multiplier/reduction datapath, where operand streams must be summed at full clock rate.

Parameters:
BIT_LEN, 19, input word width
ACC_EXT, 6, guard bits added above BIT_LEN; ACC_LEN = BIT_LEN + ACC_EXT
CHUNK_LEN, 5, bits resolved per cycle in RESOLVE; ACC_LEN % CHUNK_LEN must be 0 (elaboration-time check); NCHUNK = ACC_LEN / CHUNK_LEN

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block accepts beat
in_data  in  BIT_LEN  operand, unsigned, zero-extended to ACC_LEN
in_last  in  1  final beat of group
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_data  out  ACC_LEN  resolved sum modulo 2^ACC_LEN
out_overflow  out  1  present only with CSA_ACC_OVERFLOW_EN

Behaviour:
- States: IDLE, ACCUM, RESOLVE, OUTPUT. Registers: S, C (ACC_LEN each), chunk index k, chunk carry cr.
- Reset: state=IDLE, S=C=0, k=0, cr=0; in_ready=0 in the reset cycle, 1 from the cycle after; out_valid=0, out_data=0, out_overflow=0.
- in_ready = 1 in IDLE and ACCUM, 0 in RESOLVE and OUTPUT. Accept = in_valid & in_ready.
- Accept with X = zero-extended in_data: S' = S^C^X; C' = (maj(S,C,X) << 1) truncated to ACC_LEN. maj bit ACC_LEN-1 is dropped.
- IDLE: accept & !in_last -> ACCUM; accept & in_last -> RESOLVE (single-beat group). No accept -> stay, S=C=0.
- ACCUM: accept & in_last -> RESOLVE; otherwise stay. Bubbles (in_valid=0) leave S/C unchanged.
- RESOLVE: cycle j (j=0..NCHUNK-1) computes {co, r} = S[j*CL +: CL] + C[j*CL +: CL] + cr; writes r into S chunk j; cr<=co; k<=k+1. After chunk NCHUNK-1: C<=0, cr<=0, k<=0, state -> OUTPUT. Exactly NCHUNK cycles.
- Latency: last beat accepted at edge T -> out_valid high from edge T+NCHUNK+1... i.e., first cycle out_valid=1 is cycle T+NCHUNK+1 after acceptance cycle T.
- OUTPUT: out_valid=1, out_data=S, held stable until out_ready. out_valid & out_ready -> S=C=0, state IDLE; in_ready=1 the next cycle (no same-cycle input acceptance in OUTPUT).
- out_data is 0 whenever out_valid=0 (driven from S only in OUTPUT).
- Wrap: sums exceeding 2^ACC_LEN-1 wrap modulo 2^ACC_LEN; no saturation.
- in_last ignored when in_valid=0.
- rst mid-operation (any state): returns to reset values next cycle; partial group discarded, no out_valid.

Optional Feature:
CSA_ACC_OVERFLOW_EN defined: out_overflow port exists; sticky flag ovf set by any dropped maj bit during accumulation or by co of chunk NCHUNK-1; out_overflow = ovf in OUTPUT, 0 otherwise; cleared on handshake completion and rst. Not defined: no port, no ovf register; behaviour otherwise identical.

Test Plan:
BIT_LEN=8, ACC_EXT=4, CHUNK_LEN=4 (ACC_LEN=12, NCHUNK=3) for all:
Beats 0x05,0x03,0x07(last), back-to-back -> out_data=0x00F, out_valid 4 cycles after last acceptance, overflow=0.
Single beat 0xFF with in_last -> RESOLVE immediately, out_data=0x0FF.
17 beats of 0xFF, bubbles interleaved -> out_data=0x0EF (4335 mod 4096), out_overflow=1 with macro.
out_ready held low 10 cycles in OUTPUT -> out_data stable, in_ready=0 throughout; accepts new group only after handshake.
rst asserted during RESOLVE (j=1) -> next cycle IDLE, S=C=0, no out_valid; following group 0x01,0x01(last) -> 0x002.
16 beats of 0xFF (sum 4080) -> out_data=0xFF0, out_overflow=0 with macro (carry ripples across all three chunks).
